// File: rtl/serial_frame_tx_if.sv
// Handshake and serial-output bundle for serial_frame_tx.
// The master side supplies words. The slave side (the transmitter) drives the serial bit stream.
interface serial_frame_tx_if #(
   parameter int unsigned WIDTH = 8
);
   logic [WIDTH-1:0] data_in;
   logic             load;
   logic             ready;
   logic             out;
   logic             out_valid;
   logic             done;

   modport master (
      output data_in, load,
      input  ready, out, out_valid, done
   );

   modport slave (
      input  data_in, load,
      output ready, out, out_valid, done
   );
endinterface

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter. Each frame is a 4-bit preamble sent bit 3 first,
// followed by the data word sent MSB first. A word can be accepted on the last
// data bit, so back-to-back frames have no idle gap.
module serial_frame_tx #(
   parameter int unsigned WIDTH    = 8,
   parameter logic [3:0]  PREAMBLE = 4'b1101
) (
   input  logic            clk,
   input  logic            reset,
   serial_frame_tx_if.slave bus
);

   // The counter must hold both 3 (preamble) and WIDTH-1 (data).
   localparam int unsigned CW = (WIDTH > 4) ? $clog2(WIDTH) : 2;

   typedef enum logic [1:0] {IDLE, PRE, DATA} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic             out_q, out_d;
   logic             vld_q, vld_d;
   logic             done_q, done_d;
   logic             ready;
   logic             accept;

   assign ready  = (state_q == IDLE) || ((state_q == DATA) && (cnt_q == '0));
   assign accept = bus.load && ready;

   assign bus.ready     = ready;
   assign bus.out       = out_q;
   assign bus.out_valid = vld_q;
   assign bus.done      = done_q;

   // Next-state logic. Outputs are derived from the next state so that the
   // registered bit matches the state during the cycle that follows.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shreg_d = shreg_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = PRE;
               cnt_d   = CW'(3);
               shreg_d = bus.data_in;
            end
         end
         PRE: begin
            if (cnt_q == '0) begin
               state_d = DATA;
               cnt_d   = CW'(WIDTH - 1);
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         DATA: begin
            if (cnt_q == '0) begin
               done_d = 1'b1;
               if (accept) begin
                  state_d = PRE;
                  cnt_d   = CW'(3);
                  shreg_d = bus.data_in;
               end else begin
                  state_d = IDLE;
                  shreg_d = shreg_q << 1;
               end
            end else begin
               cnt_d   = cnt_q - CW'(1);
               shreg_d = shreg_q << 1;
            end
         end
         default: state_d = IDLE;
      endcase

      out_d = 1'b0;
      vld_d = 1'b0;
      case (state_d)
         PRE: begin
            out_d = PREAMBLE[cnt_d[1:0]];
            vld_d = 1'b1;
         end
         DATA: begin
            out_d = shreg_d[WIDTH-1];
            vld_d = 1'b1;
         end
         default: begin
            out_d = 1'b0;
            vld_d = 1'b0;
         end
      endcase
   end

   // State, counter, shift register and registered outputs; reset aborts any frame.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         shreg_q <= '0;
         out_q   <= 1'b0;
         vld_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shreg_q <= shreg_d;
         out_q   <= out_d;
         vld_q   <= vld_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx. The reference model is a queue of frame bits:
// each accepted word appends 4+W bits, and each clock consumes one bit.
module tb_serial_frame_tx;

   localparam int unsigned W       = 8;
   localparam logic [3:0]  PRE_PAT = 4'b1101;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   serial_frame_tx_if #(.WIDTH(W)) bus ();

   serial_frame_tx #(.WIDTH(W), .PREAMBLE(PRE_PAT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      bit b;
      int pos;
   } fbit_t;

   fbit_t q[$];
   bit    exp_done;
   bit    exp_det;
   bit    chk_det;
   int    det_cnt;
   int    compared   = 0;
   int    mismatched = 0;

   // Moore 1101 detector on the receiving end of the link
   logic [3:0] hist;
   logic       det;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hist <= '0;
         det  <= 1'b0;
      end else if (bus.out_valid) begin
         hist <= {hist[2:0], bus.out};
         det  <= ({hist[2:0], bus.out} == 4'b1101);
      end else begin
         det <= 1'b0;
      end
   end

   task automatic check(input string tag, input logic obs, input logic expv);
      compared++;
      assert (obs === expv) else begin
         mismatched++;
         $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, expv, $time);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int expv);
      compared++;
      assert (obs === expv) else begin
         mismatched++;
         $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, expv, $time);
      end
   endtask

   task automatic push_frame(input logic [W-1:0] d);
      fbit_t f;
      for (int i = 0; i < 4; i++) begin
         f.b   = PRE_PAT[3-i];
         f.pos = i;
         q.push_back(f);
      end
      for (int i = 0; i < int'(W); i++) begin
         f.b   = d[W-1-i];
         f.pos = 4 + i;
         q.push_back(f);
      end
   endtask

   // Called just after a falling edge: check outputs, drive inputs, advance one clock.
   task automatic tick(input logic ld, input logic [W-1:0] d);
      bit mready;
      bit acc;
      check("out_valid", bus.out_valid, q.size() > 0);
      check("out", bus.out, (q.size() > 0) ? q[0].b : 1'b0);
      check("ready", bus.ready, q.size() <= 1);
      check("done", bus.done, exp_done);
      if (chk_det) begin
         check("det", det, exp_det);
         if (det) det_cnt++;
      end
      mready      = (q.size() <= 1);
      bus.load    = ld;
      bus.data_in = d;
      @(posedge clk);
      acc = ld && mready && reset;
      if (!reset) begin
         q.delete();
         exp_done = 1'b0;
         exp_det  = 1'b0;
      end else begin
         exp_done = (q.size() == 1);
         exp_det  = (q.size() > 0) && (q[0].pos == 3);
         if (q.size() > 0) void'(q.pop_front());
         if (acc) push_frame(d);
      end
      @(negedge clk);
   endtask

   initial begin
      reset       = 1'b0;
      bus.load    = 1'b1;
      bus.data_in = 8'hA5;
      chk_det     = 1'b0;
      det_cnt     = 0;
      exp_done    = 1'b0;
      exp_det     = 1'b0;

      // Reset with load held high
      #1;
      check("rst_out", bus.out, 1'b0);
      check("rst_valid", bus.out_valid, 1'b0);
      check("rst_done", bus.done, 1'b0);
      check("rst_ready", bus.ready, 1'b1);
      @(negedge clk);
      repeat (4) tick(1'b1, 8'hA5);
      bus.load = 1'b0;
      reset    = 1'b1;
      tick(1'b0, '0);

      // Single frame of A5
      tick(1'b1, 8'hA5);
      repeat (15) tick(1'b0, '0);

      // Back-to-back 0F then F0
      tick(1'b1, 8'h0F);
      repeat (12) tick(1'b1, 8'hF0);
      repeat (14) tick(1'b0, '0);

      // Loads while busy are ignored (preamble bit 1 and data bit 5)
      tick(1'b1, 8'h3C);
      tick(1'b0, '0);
      tick(1'b1, 8'hFF);
      repeat (4) tick(1'b0, '0);
      tick(1'b1, 8'hFF);
      repeat (14) tick(1'b0, '0);

      // Reset asserted during data bit 3 of A5
      tick(1'b1, 8'hA5);
      repeat (8) tick(1'b0, '0);
      check("pre_abort_valid", bus.out_valid, 1'b1);
      #2 reset = 1'b0;
      #1;
      check("abort_out", bus.out, 1'b0);
      check("abort_valid", bus.out_valid, 1'b0);
      check("abort_ready", bus.ready, 1'b1);
      q.delete();
      exp_done = 1'b0;
      exp_det  = 1'b0;
      @(negedge clk);
      repeat (2) tick(1'b0, '0);
      reset = 1'b1;
      tick(1'b0, '0);
      tick(1'b1, 8'h81);
      repeat (14) tick(1'b0, '0);

      // Loopback: three back-to-back frames of 00 into the detector
      chk_det = 1'b1;
      tick(1'b1, 8'h00);
      repeat (24) tick(1'b1, 8'h00);
      repeat (14) tick(1'b0, '0);
      chk_det = 1'b0;
      check_int("det_count", det_cnt, 3);

      // Random loads and data
      repeat (600) tick(logic'($urandom_range(0, 2) == 0), W'($urandom));
      repeat (14) tick(1'b0, '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/serial_frame_tx.md
# serial_frame_tx

Serial frame transmitter, the sending end of the single-bit serial link. It accepts a parallel word through a valid/ready handshake and emits a frame one bit per clock: a 4-bit sync preamble 1101, then the data word MSB first. The downstream Moore overlapping sequence detector locks onto the preamble. Back-to-back frames are supported with no idle gap.

## Interface
- WIDTH, 8: data word width in bits, at least 2.
- PREAMBLE, 4'b1101: 4-bit sync pattern, sent bit 3 first.

- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- data_in  input  WIDTH  word to transmit; sampled on the accept edge.
- load  input  1  request to transmit data_in.
- ready  output  1  block can accept a word this cycle.
- out  output  1  serial bit; 0 when idle.
- out_valid  output  1  out carries a frame bit.
- done  output  1  one-cycle pulse after the last data bit of a frame.

## Operation
- States:
  - IDLE: no frame in progress.
  - PRE: sending the preamble; bit counter runs 3..0.
  - DATA: sending the data word; bit counter runs WIDTH-1..0.
- Accept happens on a rising edge where load=1 and ready=1. data_in is captured into a shift register at that edge.
- ready is combinational from the state: 1 in IDLE, and 1 in DATA when counter=0 (last data bit). It is 0 otherwise.
- IDLE transitions:
  - accept → PRE, counter=3.
  - otherwise stay in IDLE.
- PRE transitions:
  - counter decrements each cycle.
  - at counter=0 → DATA, counter=WIDTH-1.
- DATA transitions:
  - counter decrements each cycle, and the shift register shifts left.
  - at counter=0 with accept → PRE, counter=3, new word captured (back-to-back).
  - at counter=0 without accept → IDLE.
- Outputs are registered.
  - In PRE: out=PREAMBLE[counter].
  - In DATA: out=shreg[WIDTH-1].
  - out_valid=1 in PRE and DATA, 0 in IDLE.
- done is registered and goes high for one cycle on the cycle after the last data bit. With back-to-back frames it coincides with the first preamble bit of the next frame.
- load while ready=0 is ignored. It is not queued, and data_in may change freely.
- The preamble and data are not stuffed. A 1101 inside the data is allowed, and the receiver is responsible for framing.

## Timing
- Reset (reset=0) takes effect immediately and asynchronously. Forced values:
  - state=IDLE, counter=0, shreg=0
  - out=0, out_valid=0, done=0
  - ready=1
- An asserted reset mid-frame aborts the frame; no further bits are sent. After reset is released, the first accept starts a fresh frame.
- Latency: accept on edge E0 means the first preamble bit is on out/out_valid from E0 until E1. Data bit WIDTH-1 appears after edge E4.
- Frame length: 4+WIDTH cycles of out_valid=1. done is high for the single cycle starting at edge E(4+WIDTH).
- Back-to-back: an accept at the last data bit gives out_valid continuously high across frames, with zero gap.
- An accept on the same edge that reset is released is not guaranteed. The first accept is valid one edge after release.

## Test plan
- Reset: hold reset=0 with load=1. Required: out=0, out_valid=0, done=0, ready=1; no frame starts until after release.
- Single frame:
  - Stimulus: load 8'hA5 once.
  - out over 12 valid cycles: 1,1,0,1,1,0,1,0,0,1,0,1.
  - ready=0 for cycles 1-10 and 1 at cycle 11 (last data bit).
  - done=1 for exactly one cycle, then IDLE with out=0.
- Back-to-back:
  - Stimulus: load 8'h0F, hold load=1 with data_in=8'hF0 until the second accept.
  - Required: 24 contiguous valid bits 1101 00001111 1101 11110000.
  - done pulses at the first bit of frame 2 and after the last bit of frame 2.
- Busy load ignored: while sending 8'h3C, pulse load with 8'hFF during the preamble and during data bit 5. Required: transmitted word is still 00111100, and no second frame is sent.
- Reset mid-frame: assert reset during data bit 3 of 8'hA5. Required: out and out_valid drop to 0 immediately, without waiting for a clock edge. A subsequent load of 8'h81 sends 1101 10000001 cleanly.
- Loopback to the Moore 1101 detector:
  - Stimulus: three back-to-back frames of 8'h00.
  - Required: the detector asserts exactly three times, each one cycle after the last preamble bit of a frame.
